// File: rtl/hack_boot_sequencer.sv
// Boot/run controller: streams a program image into the SoC ROM loader, then releases the CPU
// and produces a prescaled, pausable, single-steppable CPU clock enable.
module hack_boot_sequencer #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned COUNT_WIDTH = 16,
  parameter int unsigned ACK_TIMEOUT = 1023,
  parameter int unsigned CLK_DIV     = 32768
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] word_count,
  input  logic                   s_valid,
  input  logic [DATA_WIDTH-1:0]  s_data,
  output logic                   s_ready,
  output logic                   rom_loader_load,
  output logic                   rom_loader_sck,
  output logic [DATA_WIDTH-1:0]  rom_loader_data,
  input  logic                   rom_loader_ack,
  output logic                   hack_external_reset,
  input  logic                   pause_toggle,
  input  logic                   step,
  output logic                   cpu_clk_en,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [COUNT_WIDTH-1:0] words_loaded
);

  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [TW-1:0] TcntLast = TW'(ACK_TIMEOUT - 1);
  localparam logic [PW-1:0] PrescMax = PW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    StIdle, StFetch, StStrobe, StWaitAck, StRelease, StRun, StError
  } state_e;

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] target_q, target_d;
  logic [COUNT_WIDTH-1:0] words_d, words_inc;
  logic [TW-1:0]          tcnt_q, tcnt_d;
  logic [PW-1:0]          presc_q, presc_d;
  logic                   paused_q, paused_d;
  logic [DATA_WIDTH-1:0]  data_d;
  logic                   clk_en_d;

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    words_d   = words_loaded;
    words_inc = words_loaded + COUNT_WIDTH'(1);
    tcnt_d    = tcnt_q;
    data_d    = rom_loader_data;
    presc_d   = '0;
    paused_d  = paused_q ^ pause_toggle;

    case (state_q)
      StIdle, StRun, StError: begin
        if (start) begin
          target_d = word_count;
          words_d  = '0;
          state_d  = (word_count == '0) ? StRelease : StFetch;
        end
      end
      StFetch: begin
        if (s_valid) begin
          data_d  = s_data;
          state_d = StStrobe;
        end
      end
      StStrobe: begin
        tcnt_d  = '0;
        state_d = StWaitAck;
      end
      StWaitAck: begin
        if (rom_loader_ack) begin
          words_d = words_inc;
          state_d = (words_inc == target_q) ? StRelease : StFetch;
        end else if (tcnt_q == TcntLast) begin
          state_d = StError;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      StRelease: state_d = StRun;
      default:   state_d = StIdle;
    endcase

    // Prescaler only runs while staying in RUN; entering or leaving RUN restarts it at zero.
    if (state_q == StRun && state_d == StRun) begin
      presc_d = (presc_q == PrescMax) ? '0 : presc_q + PW'(1);
    end

    // A step is honoured only while paused and not overridden by a same-cycle toggle.
    clk_en_d = (state_d == StRun) &&
               (((presc_d == PrescMax) && !paused_d) || (step && paused_q && !pause_toggle));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q             <= StIdle;
      target_q            <= '0;
      tcnt_q              <= '0;
      presc_q             <= '0;
      paused_q            <= 1'b0;
      words_loaded        <= '0;
      rom_loader_data     <= '0;
      s_ready             <= 1'b0;
      rom_loader_load     <= 1'b0;
      rom_loader_sck      <= 1'b0;
      hack_external_reset <= 1'b1;
      cpu_clk_en          <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
      error               <= 1'b0;
    end else begin
      state_q             <= state_d;
      target_q            <= target_d;
      tcnt_q              <= tcnt_d;
      presc_q             <= presc_d;
      paused_q            <= paused_d;
      words_loaded        <= words_d;
      rom_loader_data     <= data_d;
      s_ready             <= (state_d == StFetch);
      rom_loader_load     <= (state_d inside {StFetch, StStrobe, StWaitAck});
      rom_loader_sck      <= (state_d == StStrobe);
      hack_external_reset <= (state_d != StRun);
      cpu_clk_en          <= clk_en_d;
      busy                <= (state_d inside {StFetch, StStrobe, StWaitAck, StRelease});
      done                <= (state_d == StRun);
      error               <= (state_d == StError);
    end
  end

endmodule

// File: tb/tb_hack_boot_sequencer.sv
// Self-checking bench: per-cycle comparison against a behavioural model plus directed scenarios
// with hand-computed expectations.
module tb_hack_boot_sequencer;

  localparam int DW     = 16;
  localparam int CW     = 8;
  localparam int ACK_TO = 8;
  localparam int DIV    = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] word_count = '0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic          rom_loader_load;
  logic          rom_loader_sck;
  logic [DW-1:0] rom_loader_data;
  logic          rom_loader_ack = 1'b0;
  logic          hack_external_reset;
  logic          pause_toggle = 1'b0;
  logic          step = 1'b0;
  logic          cpu_clk_en;
  logic          busy;
  logic          done;
  logic          error;
  logic [CW-1:0] words_loaded;

  hack_boot_sequencer #(
    .DATA_WIDTH (DW),
    .COUNT_WIDTH(CW),
    .ACK_TIMEOUT(ACK_TO),
    .CLK_DIV    (DIV)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .start              (start),
    .word_count         (word_count),
    .s_valid            (s_valid),
    .s_data             (s_data),
    .s_ready            (s_ready),
    .rom_loader_load    (rom_loader_load),
    .rom_loader_sck     (rom_loader_sck),
    .rom_loader_data    (rom_loader_data),
    .rom_loader_ack     (rom_loader_ack),
    .hack_external_reset(hack_external_reset),
    .pause_toggle       (pause_toggle),
    .step               (step),
    .cpu_clk_en         (cpu_clk_en),
    .busy               (busy),
    .done               (done),
    .error              (error),
    .words_loaded       (words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stimulus modes: valid 0=always 1=random; data 0=fixed list 1=random; ack 0=never 1=next 2=random
  int valid_mode = 0;
  int data_mode  = 0;
  int ack_mode   = 1;
  logic [DW-1:0] fixed_words [3] = '{16'h0002, 16'hE308, 16'h0000};
  logic [DW-1:0] sck_log [$];
  int en_count = 0;

  initial begin
    logic last_sck;
    last_sck = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ack_mode)
        1:       rom_loader_ack = last_sck;
        2:       rom_loader_ack = 1'($urandom % 2);
        default: rom_loader_ack = 1'b0;
      endcase
      last_sck = rom_loader_sck;
      s_valid  = (valid_mode == 1) ? 1'($urandom % 2) : 1'b1;
      s_data   = (data_mode == 1) ? DW'($urandom) : fixed_words[sck_log.size() % 3];
    end
  end

  // Behavioural model: mode per spec state, RUN phase from cycles spent in RUN.
  localparam int MIdle = 0, MFetch = 1, MStrobe = 2, MWait = 3, MRel = 4, MRun = 5, MError = 6;
  int            m_mode = MIdle;
  int            m_loaded, m_target, m_waited, m_run_age;
  bit            m_paused, m_en;
  logic [DW-1:0] m_data;
  logic [DW-1:0] exp_q [$];
  bit            armed = 0;

  initial begin
    bit np, sp;
    logic [DW-1:0] front;
    forever begin
      @(negedge clk);
      if (armed) begin
        check("s_ready", s_ready, m_mode == MFetch);
        check("load", rom_loader_load, m_mode inside {MFetch, MStrobe, MWait});
        check("sck", rom_loader_sck, m_mode == MStrobe);
        check("data", rom_loader_data, m_data);
        check("ext_reset", hack_external_reset, m_mode != MRun);
        check("cpu_clk_en", cpu_clk_en, m_en);
        check("busy", busy, m_mode inside {MFetch, MStrobe, MWait, MRel});
        check("done", done, m_mode == MRun);
        check("error", error, m_mode == MError);
        check("words_loaded", words_loaded, m_loaded);
        if (rom_loader_sck === 1'b1) begin
          sck_log.push_back(rom_loader_data);
          if (exp_q.size() == 0) check("sck_unexpected", 1, 0);
          else begin
            front = exp_q.pop_front();
            check("sck_order", rom_loader_data, front);
          end
        end
        if (cpu_clk_en === 1'b1) en_count++;
      end
      // Advance the model with the inputs the DUT samples at the next rising edge.
      if (!reset_n) begin
        m_mode = MIdle; m_loaded = 0; m_target = 0; m_waited = 0; m_run_age = 0;
        m_paused = 0; m_en = 0; m_data = '0; exp_q.delete(); armed = 1;
      end else begin
        np = m_paused ^ pause_toggle;
        sp = step && m_paused && !pause_toggle;
        case (m_mode)
          MIdle, MRun, MError: begin
            if (start) begin
              m_target = int'(word_count);
              m_loaded = 0;
              m_mode   = (word_count == 0) ? MRel : MFetch;
            end else if (m_mode == MRun) m_run_age++;
          end
          MFetch: if (s_valid) begin
            m_data = s_data; exp_q.push_back(s_data); m_mode = MStrobe;
          end
          MStrobe: begin m_waited = 0; m_mode = MWait; end
          MWait: begin
            if (rom_loader_ack) begin
              m_loaded++;
              m_mode = (m_loaded == m_target) ? MRel : MFetch;
            end else begin
              m_waited++;
              if (m_waited == ACK_TO) m_mode = MError;
            end
          end
          MRel: begin m_mode = MRun; m_run_age = 0; end
          default: m_mode = MIdle;
        endcase
        m_en     = (m_mode == MRun) && ((((m_run_age % DIV) == DIV - 1) && !np) || sp);
        m_paused = np;
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_start(input int wc);
    word_count = CW'(wc);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, input bit rand_start);
    int c;
    c = 0;
    while (!done && !error && c < bound) begin
      start = rand_start ? 1'($urandom % 8 == 0) : 1'b0;
      tick();
      c++;
    end
    start = 1'b0;
  endtask

  initial begin
    int c;
    tick(3);
    check("rst_ext_reset", hack_external_reset, 1);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    reset_n = 1'b1;
    tick(2);

    // Basic load: three fixed words, ack one cycle after each strobe.
    sck_log.delete();
    pulse_start(3);
    check("fetch_load", rom_loader_load, 1);
    check("fetch_ready", s_ready, 1);
    c = 0;
    while (!done && c < 40) begin tick(); c++; end
    check("basic_cycles", c, 10);
    check("basic_sck_count", sck_log.size(), 3);
    if (sck_log.size() == 3) begin
      check("basic_w0", sck_log[0], 16'h0002);
      check("basic_w1", sck_log[1], 16'hE308);
      check("basic_w2", sck_log[2], 16'h0000);
    end
    check("basic_loaded", words_loaded, 3);
    check("basic_released", hack_external_reset, 0);

    // Run control at CLK_DIV=4.
    en_count = 0; tick(16);
    check("run_en_count", en_count, 4);
    pause_toggle = 1'b1; tick(); pause_toggle = 1'b0;
    en_count = 0; tick(12);
    check("paused_en_count", en_count, 0);
    en_count = 0;
    step = 1'b1; tick(); step = 1'b0;
    check("step_en", cpu_clk_en, 1);
    tick(8);
    check("step_en_count", en_count, 1);
    pause_toggle = 1'b1; step = 1'b1; tick(); pause_toggle = 1'b0; step = 1'b0;
    en_count = 0; tick(16);
    check("resume_en_count", en_count, 4);

    // Reload from RUN while paused; pause must survive the reload.
    pause_toggle = 1'b1; tick(); pause_toggle = 1'b0;
    valid_mode = 1; data_mode = 1;
    pulse_start(2);
    check("reload_ext_reset", hack_external_reset, 1);
    check("reload_load", rom_loader_load, 1);
    wait_done(200, 1'b0);
    check("reload_done", done, 1);
    check("reload_loaded", words_loaded, 2);
    en_count = 0; tick(12);
    check("reload_paused", en_count, 0);
    pause_toggle = 1'b1; tick(); pause_toggle = 1'b0;

    // Zero-length load.
    sck_log.delete();
    pulse_start(0);
    check("zero_load", rom_loader_load, 0);
    check("zero_busy", busy, 1);
    tick();
    check("zero_done", done, 1);
    check("zero_sck", sck_log.size(), 0);

    // Ack timeout.
    ack_mode = 0; valid_mode = 0;
    pulse_start(4);
    c = 0;
    while (!rom_loader_sck && c < 20) begin tick(); c++; end
    check("to_saw_sck", rom_loader_sck, 1);
    c = 0;
    while (!error && c < 40) begin tick(); c++; end
    check("to_cycles", c, 9);
    check("to_ext_reset", hack_external_reset, 1);
    check("to_loaded", words_loaded, 0);
    ack_mode = 1;
    pulse_start(2);
    wait_done(100, 1'b0);
    check("to_reload_done", done, 1);
    check("to_reload_loaded", words_loaded, 2);

    // Back-pressure, then reset mid-load.
    valid_mode = 1;
    pulse_start(5);
    c = 0;
    while (words_loaded < 2 && !error && c < 200) begin tick(); c++; end
    check("bp_two_loaded", words_loaded, 2);
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    check("mid_rst_load", rom_loader_load, 0);
    check("mid_rst_ext_reset", hack_external_reset, 1);
    check("mid_rst_loaded", words_loaded, 0);
    check("mid_rst_busy", busy, 0);
    tick(2);

    // Randomised loads with spurious starts, random acks and random run control.
    ack_mode = 2;
    for (int it = 0; it < 8; it++) begin
      pulse_start(int'($urandom_range(0, 6)));
      wait_done(400, 1'b1);
      for (int k = 0; k < 30; k++) begin
        pause_toggle = 1'($urandom % 6 == 0);
        step         = 1'($urandom % 3 == 0);
        tick();
      end
      pause_toggle = 1'b0; step = 1'b0;
    end
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
